uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FRQ, default 27_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate in Hz.
REQ-003 Port clk  input  1  system clock; all state is updated on the rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port rx_in  input  1  asynchronous serial line, 8N1 framing, idle high.
REQ-006 Port rx_clear  input  1  single-cycle consumer acknowledge; clears the status flags.
REQ-007 Port rx_data  output  8  last correctly framed byte received.
REQ-008 Port rx_data_ready  output  1  rx_data holds an unconsumed byte.
REQ-009 Port rx_overrun  output  1  a byte arrived while rx_data_ready was still set.
REQ-010 Port rx_frame_err  output  1  a frame had its stop bit sampled low.

Function
REQ-011 The block SHALL use the constant DIV = CLK_FRQ/BAUD_RATE (integer truncation; 234 at the defaults) and the constant HALF = DIV/2 (117 at the defaults).
REQ-012 rx_in SHALL pass through a 2-flop synchronizer, reset to 1, before any use; the synchronizer output is called rx_s.
REQ-013 The FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-014 IDLE: when rx_s is 0, the FSM SHALL go to START with the bit-timer cleared.
REQ-015 START: when the bit-timer reaches HALF-1, the FSM SHALL sample rx_s.
  - rx_s = 0: go to DATA, clear the bit-timer, clear the bit index.
  - rx_s = 1 (glitch): go to IDLE; no flag changes.
REQ-016 DATA: each time the bit-timer reaches DIV-1, the FSM SHALL sample rx_s into the shift register LSB first and restart the timer; after the 8th sample it SHALL go to STOP.
REQ-017 STOP: when the bit-timer reaches DIV-1, the FSM SHALL sample rx_s.
  - rx_s = 1: load rx_data, set rx_data_ready, go to IDLE.
  - rx_s = 0: leave rx_data unchanged, set rx_frame_err, go to WAIT_IDLE.
REQ-018 WAIT_IDLE SHALL go to IDLE on the first cycle rx_s is 1; a break of any length SHALL produce exactly one rx_frame_err.
REQ-019 All flag and data updates SHALL be visible the cycle after the stop-bit sampling edge.
REQ-020 End-to-end latency SHALL be 2 (synchronizer) + HALF + 9*DIV clocks, ±1, from the rx_in falling edge to rx_data_ready rising.
REQ-021 If a good stop bit is sampled while rx_data_ready = 1 and rx_clear = 0, the block SHALL set rx_overrun and overwrite rx_data with the newest byte.
REQ-022 rx_clear = 1 SHALL clear rx_data_ready, rx_overrun and rx_frame_err on the next edge.
REQ-023 If rx_clear coincides with a load, the load SHALL win: rx_data_ready stays 1 and rx_overrun is not set.
REQ-024 The bit-timer SHALL be wide enough for DIV-1 (clog2) and SHALL never wrap within a state.
REQ-025 The block SHALL be receive-only, with no parity support and no baud auto-detect.

Reset
REQ-026 While reset is high, the block SHALL hold:
  - FSM = IDLE;
  - bit-timer, bit index, shift register and rx_data = 0;
  - rx_data_ready, rx_overrun, rx_frame_err = 0;
  - synchronizer flops = 1.
REQ-027 Reset asserted mid-frame SHALL discard the partial byte.
REQ-028 After reset releases, reception SHALL restart only on a fresh falling edge of rx_s.

Structure
REQ-029 The FSM state encoding and the DIV/HALF derivation SHALL live in the shared uart package, also used by uart_tx.
REQ-030 A single sub-module, sync2 (2-flop synchronizer, reset value parameterised), is natural; everything else SHALL be flat in uart_rx.

Verification
REQ-031 Send 0x55 at 115200 baud with 27 MHz clk -> rx_data = 0x55, rx_data_ready = 1 within 2+117+9*234 ±1 clocks, rx_frame_err = 0, rx_overrun = 0.
REQ-032 Send 0xA3 then 0x3C back-to-back without rx_clear -> rx_data = 0x3C, rx_overrun = 1; rx_clear pulse -> all three flags 0 next cycle.
REQ-033 Drive a 50-clock low glitch on an idle line -> FSM returns to IDLE, no flag changes, rx_data unchanged.
REQ-034 Send 0xF0 with stop bit held low for 3 bit times -> rx_frame_err = 1, rx_data_ready = 0, rx_data unchanged; a following good 0x81 -> rx_data = 0x81.
REQ-035 Assert reset midway through the data bits of 0x7E, release, then send 0x42 -> only 0x42 is reported, no error flags.
REQ-036 Pulse rx_clear on the exact cycle 0x99 loads, with rx_data_ready already 1 -> rx_data_ready = 1, rx_overrun = 0, rx_data = 0x99.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud divisor derivation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_state_e;

  // Clocks per bit, truncated.
  function automatic int unsigned uart_div(input int unsigned clk_frq,
                                           input int unsigned baud_rate);
    return clk_frq / baud_rate;
  endfunction

  // Clocks to the middle of a bit.
  function automatic int unsigned uart_half(input int unsigned clk_frq,
                                            input int unsigned baud_rate);
    return uart_div(clk_frq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit, reset value selectable.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, sticky ready/overrun/frame-error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRQ   = 27_000_000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       rx_clear,
  output logic [7:0] rx_data,
  output logic       rx_data_ready,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int unsigned DIV  = uart_div(CLK_FRQ, BAUD_RATE);
  localparam int unsigned HALF = uart_half(CLK_FRQ, BAUD_RATE);
  localparam int unsigned TW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] DIV_M1  = TW'(DIV - 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);

  logic          rx_s;
  uart_state_e   state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          ready_q;
  logic          ovr_q;
  logic          ferr_q;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (reset),
    .d_i (rx_in),
    .q_o (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      // Consumer acknowledge; a load or error below on the same edge takes priority.
      if (rx_clear) begin
        ready_q <= 1'b0;
        ovr_q   <= 1'b0;
        ferr_q  <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            timer_q <= '0;
          end
        end

        START: begin
          if (timer_q == HALF_M1) begin
            timer_q <= '0;
            idx_q   <= '0;
            state_q <= rx_s ? IDLE : DATA;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        DATA: begin
          if (timer_q == DIV_M1) begin
            timer_q <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= STOP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        STOP: begin
          if (timer_q == DIV_M1) begin
            timer_q <= '0;
            if (rx_s) begin
              data_q  <= shift_q;
              ready_q <= 1'b1;
              if (ready_q && !rx_clear) ovr_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_IDLE;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        WAIT_IDLE: begin
          if (rx_s) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data       = data_q;
  assign rx_data_ready = ready_q;
  assign rx_overrun    = ovr_q;
  assign rx_frame_err  = ferr_q;

endmodule
